timer_periph: RTL and testbench



---
 rtl/timer_periph_pkg.sv | 18 +
 rtl/timer_counter.sv | 61 ++++++
 rtl/timer_periph.sv | 115 +++++++++++
 tb/tb_timer_periph.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_periph_pkg.sv
// timer_periph_pkg: shared constants for the memory-mapped timer peripheral.
//   Register byte offsets inside the 32-byte window, TCON bit positions and
//   the TL terminal count. Optional macro TIMER_PRESCALE_EN (see timer_periph).
package timer_periph_pkg;

   localparam logic [4:0] OFF_TH      = 5'h00;
   localparam logic [4:0] OFF_TL      = 5'h04;
   localparam logic [4:0] OFF_TCON    = 5'h08;
   localparam logic [4:0] OFF_PRESC   = 5'h0C;
   localparam logic [4:0] OFF_SYSTICK = 5'h10;

   localparam int TCON_EN  = 0;
   localparam int TCON_IE  = 1;
   localparam int TCON_IRQ = 2;

   localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: TL counter with reload from TH and optional prescaler.
//   clk, reset      : clock, async active-low reset
//   en              : TCON.EN
//   th              : reload value (current TH, so a same-cycle TH write is not seen)
//   tl_we/tl_wdata  : software TL write, overrides increment and reload
//   presc_we/presc_wdata/presc : PRESC write and readback (TIMER_PRESCALE_EN only)
//   tl              : current counter value
//   reload          : high on the cycle whose clock edge reloads TL from TH
// Macro TIMER_PRESCALE_EN adds the prescaler; without it TL advances every
// enabled cycle.
module timer_counter
   import timer_periph_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] th,
   input  logic        tl_we,
   input  logic [31:0] tl_wdata,
`ifdef TIMER_PRESCALE_EN
   input  logic        presc_we,
   input  logic [15:0] presc_wdata,
   output logic [15:0] presc,
`endif
   output logic [31:0] tl,
   output logic        reload
);

   logic tick;

`ifdef TIMER_PRESCALE_EN
   logic [15:0] pcnt;

   // TL advances when the prescale count has reached PRESC; PRESC = 0 ticks every cycle.
   assign tick = (pcnt == presc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         pcnt  <= '0;
      end else if (presc_we) begin
         presc <= presc_wdata;
         pcnt  <= '0;
      end else if (en) begin
         pcnt  <= tick ? 16'd0 : pcnt + 16'd1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   assign reload = en & tick & (tl == TL_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         tl <= '0;
      else if (tl_we)     tl <= tl_wdata;
      else if (reload)    tl <= th;
      else if (en & tick) tl <= tl + 32'd1;
   end

endmodule

// File: rtl/timer_periph.sv
// timer_periph: memory-mapped timer beside the CPU data memory.
//   clk, reset  : clock, async active-low reset
//   MemRead     : load strobe (EX/MEM)
//   MemWrite    : store strobe (EX/MEM); wins over MemRead
//   Address     : byte address, window is Address[31:5] == BASE_ADDR[31:5]
//   WriteData   : store data
//   ReadData    : registered read data, 0 when the last cycle was not a read hit
//   Hit         : registered MemRead & in-window, selects ReadData in WB
//   Interrupt   : IE & IRQ level request
// Registers: TH 0x00, TL 0x04, TCON 0x08 {IRQ,IE,EN}, PRESC 0x0C, SYSTICK 0x10.
// Macro TIMER_PRESCALE_EN enables PRESC; otherwise 0x0C reads 0.
module timer_periph
   import timer_periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          SYSTICK_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        Interrupt
);

   logic                 in_win, wr, rd_hit, reload;
   logic [4:0]           off;
   logic [31:0]          th, tl, rd_mux;
   logic                 en, ie, irq;
   logic [SYSTICK_W-1:0] systick;
   logic                 unused_addr;

   // Byte lanes are ignored: every access is treated as a whole word.
   assign unused_addr = ^Address[1:0];
   assign off         = {Address[4:2], 2'b00};
   assign in_win      = (Address[31:5] == BASE_ADDR[31:5]);
   assign wr          = MemWrite & in_win;
   assign rd_hit      = MemRead & in_win & ~MemWrite;

`ifdef TIMER_PRESCALE_EN
   logic [15:0] presc;
`endif

   timer_counter u_cnt (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .th         (th),
      .tl_we      (wr && off == OFF_TL),
      .tl_wdata   (WriteData),
`ifdef TIMER_PRESCALE_EN
      .presc_we   (wr && off == OFF_PRESC),
      .presc_wdata(WriteData[15:0]),
      .presc      (presc),
`endif
      .tl         (tl),
      .reload     (reload)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th      <= '0;
         en      <= 1'b0;
         ie      <= 1'b0;
         irq     <= 1'b0;
         systick <= '0;
      end else begin
         systick <= systick + SYSTICK_W'(1);
         if (wr && off == OFF_TH) th <= WriteData;
         if (wr && off == OFF_TCON) begin
            en <= WriteData[TCON_EN];
            ie <= WriteData[TCON_IE];
         end
         // Hardware set beats a same-cycle software clear; writing 1 never sets.
         if (reload & ie)
            irq <= 1'b1;
         else if (wr && off == OFF_TCON && !WriteData[TCON_IRQ])
            irq <= 1'b0;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_TH:      rd_mux = th;
         OFF_TL:      rd_mux = tl;
         OFF_TCON: begin
            rd_mux[TCON_EN]  = en;
            rd_mux[TCON_IE]  = ie;
            rd_mux[TCON_IRQ] = irq;
         end
`ifdef TIMER_PRESCALE_EN
         OFF_PRESC:   rd_mux = {16'd0, presc};
`endif
         OFF_SYSTICK: rd_mux = 32'(systick);
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ReadData <= '0;
         Hit      <= 1'b0;
      end else begin
         ReadData <= rd_hit ? rd_mux : 32'd0;
         Hit      <= MemRead & in_win;
      end
   end

   assign Interrupt = ie & irq;

endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph: directed scenarios plus randomized bus traffic, checked
// every cycle against a register-level model of the timer.
module tb_timer_periph;
   import timer_periph_pkg::*;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] Address = 32'd0, WriteData = 32'd0;
   logic [31:0] ReadData;
   logic        Hit, Interrupt;

   always #5 clk = ~clk;

   timer_periph #(.BASE_ADDR(BASE), .SYSTICK_W(32)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .WriteData(WriteData),
      .ReadData(ReadData), .Hit(Hit), .Interrupt(Interrupt)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] th, tl;
      logic        en, ie, irq;
      logic [15:0] presc, pcnt;
      logic [31:0] systick, rd;
      logic        hit;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t step(mdl_t c, logic mr, logic mw, logic [31:0] a, logic [31:0] wd);
      mdl_t        n;
      logic        win, wr, adv, wrap;
      logic [2:0]  w;
      logic [31:0] v;
      n   = c;
      win = ((a >> 5) == (BASE >> 5));
      w   = a[4:2];
      wr  = mw && win;
      case (w)
         3'd0:    v = c.th;
         3'd1:    v = c.tl;
         3'd2:    v = {29'd0, c.irq, c.ie, c.en};
         3'd3:    v = {16'd0, c.presc};
         3'd4:    v = c.systick;
         default: v = 32'd0;
      endcase
      n.rd  = (mr && win && !mw) ? v : 32'd0;
      n.hit = mr && win;
      adv   = c.en && (c.pcnt == c.presc);
      wrap  = adv && (c.tl == 32'hFFFF_FFFF);
      if (wr && w == 3'd1) n.tl = wd;
      else if (wrap)       n.tl = c.th;
      else if (adv)        n.tl = c.tl + 32'd1;
      if (c.en) n.pcnt = adv ? 16'd0 : c.pcnt + 16'd1;
`ifdef TIMER_PRESCALE_EN
      if (wr && w == 3'd3) begin
         n.presc = wd[15:0];
         n.pcnt  = 16'd0;
      end
`endif
      if (wr && w == 3'd0) n.th = wd;
      if (wr && w == 3'd2) begin
         n.en = wd[0];
         n.ie = wd[1];
         if (!wd[2]) n.irq = 1'b0;
      end
      if (wrap && c.ie) n.irq = 1'b1;
      n.systick = c.systick + 32'd1;
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= '0;
      else        m <= step(m, MemRead, MemWrite, Address, WriteData);
   end

   // ---------------- checking ----------------
   int checks = 0, errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model ReadData", ReadData, m.rd);
         chk("model Hit", {31'd0, Hit}, {31'd0, m.hit});
         chk("model Interrupt", {31'd0, Interrupt}, {31'd0, m.ie & m.irq});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus_addr(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd);
      MemRead = mr; MemWrite = mw; Address = a; WriteData = wd;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [4:0] o, input logic [31:0] wd);
      bus_addr(1'b0, 1'b1, BASE | {27'd0, o}, wd);
   endtask

   task automatic rd(input logic [4:0] o);
      bus_addr(1'b1, 1'b0, BASE | {27'd0, o}, 32'd0);
   endtask

   task automatic idle(input int n);
      MemRead = 1'b0; MemWrite = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [4:0] roffs [5] = '{OFF_TH, OFF_TL, OFF_TCON, OFF_PRESC, 5'h14};

   initial begin
      // reset
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      chk_en = 1'b1;
      chk("reset Interrupt", {31'd0, Interrupt}, 32'd0);
      chk("reset Hit", {31'd0, Hit}, 32'd0);
      foreach (roffs[i]) begin
         rd(roffs[i]);
         chk("reset read", ReadData, 32'd0);
         chk("reset read Hit", {31'd0, Hit}, 32'd1);
      end
      rd(OFF_SYSTICK);

      // reload and interrupt
      wr(OFF_TH, 32'hFFFF_FFF0);
      wr(OFF_TL, 32'hFFFF_FFFC);
      wr(OFF_TCON, 32'h3);
      idle(3);
      chk("pre-reload Interrupt", {31'd0, Interrupt}, 32'd0);
      idle(1);
      chk("reload Interrupt", {31'd0, Interrupt}, 32'd1);
      rd(OFF_TL);
      chk("reloaded TL", ReadData, 32'hFFFF_FFF0);
      wr(OFF_TCON, 32'h3);
      chk("IRQ clear Interrupt", {31'd0, Interrupt}, 32'd0);
      rd(OFF_TL);
      chk("TL continues", ReadData, 32'hFFFF_FFF2);

      // TL write beats reload
      wr(OFF_TCON, 32'h0);
      wr(OFF_TL, 32'hFFFF_FFFF);
      wr(OFF_TCON, 32'h1);
      wr(OFF_TL, 32'd5);
      rd(OFF_TL);
      chk("TL write wins", ReadData, 32'd5);
      rd(OFF_TL);
      chk("TL after write", ReadData, 32'd6);
      rd(OFF_TCON);
      chk("no IRQ after write", ReadData, 32'h1);

      // reload coincides with TCON write: set wins
      wr(OFF_TCON, 32'h0);
      wr(OFF_TH, 32'h100);
      wr(OFF_TL, 32'hFFFF_FFFE);
      wr(OFF_TCON, 32'h3);
      idle(1);
      wr(OFF_TCON, 32'h3);
      chk("set wins Interrupt", {31'd0, Interrupt}, 32'd1);
      rd(OFF_TCON);
      chk("set wins TCON", ReadData, 32'h7);

      // unmapped offset, out-of-window accesses, ignored byte lanes
      rd(5'h14);
      chk("unmapped read", ReadData, 32'd0);
      chk("unmapped Hit", {31'd0, Hit}, 32'd1);
      bus_addr(1'b0, 1'b1, 32'h5000_0000, 32'hDEAD_BEEF);
      rd(5'h03);
      chk("TH after outside write", ReadData, 32'h100);
      bus_addr(1'b1, 1'b0, 32'h3FFF_FFE0, 32'd0);
      chk("outside read data", ReadData, 32'd0);
      chk("outside read Hit", {31'd0, Hit}, 32'd0);
      bus_addr(1'b1, 1'b1, BASE | 32'h4, 32'h1234);
      chk("read+write data", ReadData, 32'd0);

      // prescaler
      wr(OFF_TCON, 32'h0);
      wr(OFF_PRESC, 32'd3);
      wr(OFF_TL, 32'd0);
      wr(OFF_TCON, 32'h1);
      idle(8);
      rd(OFF_TL);
`ifdef TIMER_PRESCALE_EN
      chk("prescaled TL", ReadData, 32'd2);
      rd(OFF_PRESC);
      chk("PRESC read", ReadData, 32'd3);
`else
      chk("unscaled TL", ReadData, 32'd8);
      rd(OFF_PRESC);
      chk("PRESC read", ReadData, 32'd0);
`endif

      // asynchronous reset mid-access with Interrupt high
      wr(OFF_TCON, 32'h0);
      wr(OFF_PRESC, 32'd0);
      wr(OFF_TH, 32'd0);
      wr(OFF_TL, 32'hFFFF_FFFF);
      wr(OFF_TCON, 32'h3);
      idle(1);
      chk("pre-reset Interrupt", {31'd0, Interrupt}, 32'd1);
      MemRead = 1'b1; Address = BASE | {27'd0, OFF_TL};
      #2 reset = 1'b0;
      #1;
      chk("async reset Interrupt", {31'd0, Interrupt}, 32'd0);
      chk("async reset ReadData", ReadData, 32'd0);
      MemRead = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      rd(OFF_TCON);
      chk("TCON after reset", ReadData, 32'd0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         int          op, o;
         logic [31:0] a, wd;
         op = int'($urandom_range(0, 99));
         o  = int'($urandom_range(0, 7));
         a  = BASE | (32'(o) << 2) | 32'($urandom_range(0, 3));
         case (o)
            1:       wd = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            2:       wd = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0);
            3:       wd = 32'($urandom_range(0, 3));
            default: wd = $urandom;
         endcase
         if (op == 0) begin
            idle(0);
            reset = 1'b0;
            @(posedge clk); #1 reset = 1'b1;
         end else if (op < 40) bus_addr(1'b1, 1'b0, a, wd);
         else if (op < 70)     bus_addr(1'b0, 1'b1, a, wd);
         else if (op < 78)     bus_addr(1'b1, 1'b1, a, wd);
         else if (op < 90)     idle(1);
         else bus_addr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       a ^ (32'd1 << $urandom_range(5, 31)), wd);
      end

      idle(2);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
